magnitude_peak_detector: RTL and testbench

Pipelined complex-magnitude estimator using alpha-max-plus-beta-min, with a run-time selectable coefficient mode and a valid handshake. Each block of BLOCK_LENGTH valid magnitudes is scanned for its peak, and the block reports the peak value and its sample index. It sits after the matched-filter output, where it feeds detection/threshold logic. It is the successor to the fixed max+min/4 magnitude block: it adds modes, valid qualification, and framed peak search.

---
 rtl/magnitude_peak_detector.sv | 156 +++++++++++++++
 tb/tb_magnitude_peak_detector.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/magnitude_peak_detector.sv
// Two-stage alpha-max-plus-beta-min magnitude estimator with selectable coefficients,
// followed by a framed peak search that reports the largest estimate and its index per block.
module magnitude_peak_detector #(
    parameter int DATA_WIDTH   = 18,
    parameter int BLOCK_LENGTH = 1024,
    parameter int INDEX_WIDTH  = 10
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [1:0]                   mode,
    input  logic                         dataInValid,
    input  logic signed [DATA_WIDTH-1:0] dataInRe,
    input  logic signed [DATA_WIDTH-1:0] dataInIm,
    output logic                         dataOutValid,
    output logic signed [DATA_WIDTH:0]   dataOut,
    output logic                         peakValid,
    output logic signed [DATA_WIDTH:0]   peakValue,
    output logic [INDEX_WIDTH-1:0]       peakIndex
);

    // state  | meaning
    // IDLE   | no block in progress, waiting for the first valid magnitude
    // TRACK  | scanning a block, running max/idx/count live
    // REPORT | peakValid cycle; a valid magnitude here opens the next block
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACK  = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(BLOCK_LENGTH - 1);

    logic [DATA_WIDTH-1:0]  re_abs, im_abs;
    logic [DATA_WIDTH-1:0]  s1_re, s1_im;
    logic [1:0]             s1_mode;
    logic                   s1_valid;

    logic [DATA_WIDTH-1:0]  mx, mn, term;
    logic [DATA_WIDTH:0]    mag_next;
    logic [DATA_WIDTH:0]    s2_mag;
    logic                   s2_valid;

    state_t                 state, state_nx;
    logic [DATA_WIDTH:0]    run_max, max_nx, fin_max;
    logic [INDEX_WIDTH-1:0] run_idx, idx_nx, fin_idx;
    logic [INDEX_WIDTH-1:0] count, cnt_nx;
    logic                   peak_pulse, report_nx;
    logic [DATA_WIDTH:0]    peak_value_q, pv_nx;
    logic [INDEX_WIDTH-1:0] peak_index_q, pi_nx;

    // Two's-complement negate wraps the most-negative value onto 2^(DATA_WIDTH-1) unsigned.
    assign re_abs = dataInRe[DATA_WIDTH-1] ? $unsigned(-dataInRe) : $unsigned(dataInRe);
    assign im_abs = dataInIm[DATA_WIDTH-1] ? $unsigned(-dataInIm) : $unsigned(dataInIm);

    always_comb begin
        mx   = (s1_re >= s1_im) ? s1_re : s1_im;
        mn   = (s1_re >= s1_im) ? s1_im : s1_re;
        term = '0;
        case (s1_mode)
            2'd0:    term = mn >> 2;
            2'd1:    term = (mn >> 2) + (mn >> 3);
            2'd2:    term = mn >> 1;
            default: term = '0;
        endcase
        mag_next = {1'b0, mx} + {1'b0, term};
    end

    always_comb begin
        state_nx  = state;
        max_nx    = run_max;
        idx_nx    = run_idx;
        cnt_nx    = count;
        report_nx = 1'b0;
        pv_nx     = peak_value_q;
        pi_nx     = peak_index_q;
        fin_max   = run_max;
        fin_idx   = run_idx;
        if (s2_valid && (s2_mag > run_max)) begin
            fin_max = s2_mag;
            fin_idx = count;
        end
        case (state)
            IDLE, REPORT: begin
                if (s2_valid) begin
                    max_nx   = s2_mag;
                    idx_nx   = '0;
                    cnt_nx   = INDEX_WIDTH'(1);
                    state_nx = TRACK;
                end else begin
                    state_nx = IDLE;
                end
            end
            TRACK: begin
                if (s2_valid) begin
                    max_nx = fin_max;
                    idx_nx = fin_idx;
                    if (count == LAST_IDX) begin
                        report_nx = 1'b1;
                        pv_nx     = fin_max;
                        pi_nx     = fin_idx;
                        cnt_nx    = '0;
                        state_nx  = REPORT;
                    end else begin
                        cnt_nx = count + INDEX_WIDTH'(1);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_re        <= '0;
            s1_im        <= '0;
            s1_mode      <= '0;
            s1_valid     <= 1'b0;
            s2_mag       <= '0;
            s2_valid     <= 1'b0;
            state        <= IDLE;
            run_max      <= '0;
            run_idx      <= '0;
            count        <= '0;
            peak_pulse   <= 1'b0;
            peak_value_q <= '0;
            peak_index_q <= '0;
        end else if (enable) begin
            s1_valid <= dataInValid;
            if (dataInValid) begin
                s1_re   <= re_abs;
                s1_im   <= im_abs;
                s1_mode <= mode;
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_mag <= mag_next;
            end
            state        <= state_nx;
            run_max      <= max_nx;
            run_idx      <= idx_nx;
            count        <= cnt_nx;
            peak_pulse   <= report_nx;
            peak_value_q <= pv_nx;
            peak_index_q <= pi_nx;
        end
    end

    // A stall masks the valid strobes; the registered flags survive and reappear on resume.
    assign dataOutValid = s2_valid & enable;
    assign dataOut      = s2_mag;
    assign peakValid    = peak_pulse & enable;
    assign peakValue    = peak_value_q;
    assign peakIndex    = peak_index_q;

endmodule

// File: tb/tb_magnitude_peak_detector.sv
// Directed bench for magnitude_peak_detector (BLOCK_LENGTH=4): scoreboard of expected
// magnitudes/peaks pushed at drive time and checked by a negedge monitor.
module tb_magnitude_peak_detector;

    localparam int DW = 18;
    localparam int IW = 10;
    localparam int BL = 4;

    logic                 clock;
    logic                 reset;
    logic                 enable;
    logic [1:0]           mode;
    logic                 dataInValid;
    logic signed [DW-1:0] dataInRe;
    logic signed [DW-1:0] dataInIm;
    logic                 dataOutValid;
    logic signed [DW:0]   dataOut;
    logic                 peakValid;
    logic signed [DW:0]   peakValue;
    logic [IW-1:0]        peakIndex;

    magnitude_peak_detector #(
        .DATA_WIDTH  (DW),
        .BLOCK_LENGTH(BL),
        .INDEX_WIDTH (IW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .mode        (mode),
        .dataInValid (dataInValid),
        .dataInRe    (dataInRe),
        .dataInIm    (dataInIm),
        .dataOutValid(dataOutValid),
        .dataOut     (dataOut),
        .peakValid   (peakValid),
        .peakValue   (peakValue),
        .peakIndex   (peakIndex)
    );

    typedef struct {
        logic [DW:0] val;
        int          due;
    } exp_t;

    typedef struct {
        logic [DW:0]   val;
        logic [IW-1:0] idx;
    } pk_t;

    exp_t q[$];
    pk_t  pq[$];
    int   errors     = 0;
    int   checks     = 0;
    int   en_edges   = 0;
    int   peaks_seen = 0;
    logic prev_pk    = 1'b0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (enable && !reset) en_edges <= en_edges + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input int re, input int im, input logic [1:0] m, input int exp_mag);
        exp_t e;
        enable      = 1'b1;
        dataInValid = 1'b1;
        dataInRe    = DW'(re);
        dataInIm    = DW'(im);
        mode        = m;
        e.val       = (DW+1)'(exp_mag);
        e.due       = en_edges + 2;
        q.push_back(e);
        step();
    endtask

    task automatic idle_cycles(input int n);
        dataInValid = 1'b0;
        enable      = 1'b1;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push_peak(input int v, input int idx);
        pk_t p;
        p.val = (DW+1)'(v);
        p.idx = IW'(idx);
        pq.push_back(p);
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        dataInValid = 1'b0;
        q.delete();
        pq.delete();
        step();
        step();
        reset = 1'b0;
    endtask

    always @(negedge clock) begin
        exp_t e;
        pk_t  p;
        if (!reset) begin
            if (!enable) begin
                chk("stall_out_valid", {31'd0, dataOutValid}, 32'd0);
                chk("stall_peak_valid", {31'd0, peakValid}, 32'd0);
            end
            if (dataOutValid) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", {31'd0, dataOutValid}, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("mag", 32'(unsigned'(dataOut)), 32'(e.val));
                    chk("latency", en_edges, e.due);
                end
            end else if (enable && q.size() > 0 && en_edges >= q[0].due) begin
                e = q.pop_front();
                chk("missing_out", {31'd0, dataOutValid}, 32'd1);
            end
            if (prev_pk) chk("pulse_width", {31'd0, peakValid}, 32'd0);
            if (peakValid) begin
                peaks_seen++;
                if (pq.size() == 0) begin
                    chk("unexpected_peak", {31'd0, peakValid}, 32'd0);
                end else begin
                    p = pq.pop_front();
                    chk("peak_value", 32'(unsigned'(peakValue)), 32'(p.val));
                    chk("peak_index", 32'(peakIndex), 32'(p.idx));
                end
            end
            prev_pk = peakValid;
        end else begin
            prev_pk = 1'b0;
        end
    end

    initial begin
        reset       = 1'b1;
        enable      = 1'b1;
        mode        = 2'd0;
        dataInValid = 1'b0;
        dataInRe    = '0;
        dataInIm    = '0;
        step();
        step();
        reset = 1'b0;

        @(negedge clock);
        chk("rst_dout", 32'(unsigned'(dataOut)), 32'd0);
        chk("rst_dout_valid", {31'd0, dataOutValid}, 32'd0);
        chk("rst_peak_valid", {31'd0, peakValid}, 32'd0);
        chk("rst_peak_value", 32'(unsigned'(peakValue)), 32'd0);
        chk("rst_peak_index", 32'(peakIndex), 32'd0);
        step();

        // Magnitude formula and edge inputs, back-to-back valid
        push_peak(23537, 3);
        push_peak(196608, 1);
        push_peak(131072, 1);
        send(59, 15683, 2'd0, 15697);
        send(15683, -15696, 2'd0, 19616);
        send(15683, -15696, 2'd1, 21576);
        send(15683, -15696, 2'd2, 23537);
        send(15683, -15696, 2'd3, 15696);
        send(-131072, -131072, 2'd2, 196608);
        send(-131072, -131072, 2'd0, 163840);
        send(0, 0, 2'd0, 0);
        send(0, -1357, 2'd1, 1357);
        send(-131072, 0, 2'd0, 131072);
        send(-131072, 0, 2'd1, 131072);
        send(-131072, 0, 2'd2, 131072);
        send(-131072, 0, 2'd3, 131072);
        send(0, -1357, 2'd0, 1357);
        idle_cycles(4);
        chk("drain_outs", q.size(), 0);
        chk("drain_peaks", pq.size(), 0);
        do_reset();

        // Two back-to-back blocks
        push_peak(300, 1);
        push_peak(400, 3);
        send(100, 0, 2'd0, 100);
        send(300, 0, 2'd0, 300);
        send(0, 300, 2'd0, 300);
        send(50, 0, 2'd0, 50);
        send(20, 0, 2'd0, 20);
        send(0, -10, 2'd0, 10);
        send(5, 0, 2'd0, 5);
        send(-400, 0, 2'd0, 400);
        idle_cycles(4);

        // Valid bubble and 3-cycle stall with garbage inputs presented
        push_peak(3000, 3);
        send(1000, 0, 2'd1, 1000);
        idle_cycles(1);
        send(0, 2000, 2'd2, 2000);
        enable      = 1'b0;
        dataInValid = 1'b1;
        dataInRe    = DW'(90000);
        dataInIm    = DW'(90000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("stall_hold_dout", 32'(unsigned'(dataOut)), 32'd1000);
            chk("stall_hold_peak", 32'(unsigned'(peakValue)), 32'd400);
            step();
        end
        send(500, -500, 2'd3, 500);
        send(3000, 0, 2'd0, 3000);
        idle_cycles(4);

        // Abort a partial block with reset
        send(10, 0, 2'd0, 10);
        send(20, 0, 2'd0, 20);
        do_reset();
        @(negedge clock);
        chk("rst2_peak_value", 32'(unsigned'(peakValue)), 32'd0);
        chk("rst2_peak_index", 32'(peakIndex), 32'd0);
        step();
        push_peak(777, 2);
        send(100, 0, 2'd0, 100);
        send(200, 0, 2'd0, 200);
        send(777, 0, 2'd0, 777);
        send(300, 0, 2'd0, 300);
        idle_cycles(4);
        @(negedge clock);
        chk("hold_peak_value", 32'(unsigned'(peakValue)), 32'd777);
        chk("hold_peak_index", 32'(peakIndex), 32'd2);
        step();

        chk("final_outs", q.size(), 0);
        chk("final_peaks", pq.size(), 0);
        chk("peaks_seen", peaks_seen, 7);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
